// File: rtl/rls_result_logger.sv
// Captures RLS solution words into on-chip memory and replays them over a valid/ready port.
// The run-complete strobe is named run_final because "final" is a reserved word.
module rls_result_logger #(
  parameter int nBits = 32,
  parameter int N     = 16,
  parameter int AW    = 15,
  parameter int DEPTH = 16384
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             write,
  input  logic [nBits-1:0] x,
  input  logic             run_final,
  input  logic             dump,
  input  logic             rd_ready,
  output logic [nBits-1:0] rd_data,
  output logic             rd_valid,
  output logic [AW-1:0]    rd_addr,
  output logic [AW-1:0]    wr_addr,
  output logic [15:0]      vec_count,
  output logic             overflow,
  output logic             done
);

  localparam int unsigned WW  = AW + 1;
  localparam int unsigned MAW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned EW  = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, CAPTURE, HOLD, DUMP} state_t;

  state_t           state_q, state_d;
  logic [nBits-1:0] mem [DEPTH];
  logic [WW-1:0]    wcnt;
  logic [WW-1:0]    rd_ptr;
  logic [EW-1:0]    elem;
  logic             we_c, drop_c, rd_start_c, rd_load_c;
  logic             full_c, last_c;

  // One extra count bit lets the fill level reach DEPTH without wrapping.
  assign full_c  = (wcnt >= WW'(DEPTH));
  assign last_c  = (WW'(rd_addr) == (wcnt - WW'(1)));
  assign wr_addr = AW'(wcnt);

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state and datapath strobes; reset suppresses every strobe.
  always_comb begin
    state_d    = state_q;
    we_c       = 1'b0;
    drop_c     = 1'b0;
    rd_start_c = 1'b0;
    rd_load_c  = 1'b0;
    if (!reset) begin
      case (state_q)
        IDLE: begin
          if (write) begin
            we_c    = 1'b1;
            state_d = CAPTURE;
          end else if (run_final) begin
            state_d = HOLD;
          end
        end
        CAPTURE: begin
          if (write) begin
            if (full_c) drop_c = 1'b1;
            else        we_c   = 1'b1;
          end
          if (run_final) state_d = HOLD;
        end
        HOLD: begin
          drop_c = write;
          if (dump && (wcnt != '0)) begin
            rd_start_c = 1'b1;
            state_d    = DUMP;
          end
        end
        DUMP: begin
          drop_c    = write;
          rd_load_c = !rd_valid || rd_ready;
          if (rd_valid && rd_ready && last_c) state_d = HOLD;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Storage array is never reset; the fill level alone bounds what is readable.
  always_ff @(posedge clk) begin
    if (we_c) mem[MAW'(wcnt)] <= x;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wcnt      <= '0;
      elem      <= '0;
      vec_count <= '0;
      overflow  <= 1'b0;
      done      <= 1'b0;
      rd_ptr    <= '0;
      rd_valid  <= 1'b0;
      rd_addr   <= '0;
      rd_data   <= '0;
    end else begin
      done <= (state_d == HOLD) || (state_d == DUMP);
      if (drop_c) overflow <= 1'b1;
      if (we_c) begin
        wcnt <= wcnt + WW'(1);
        if (elem == EW'(N - 1)) begin
          elem <= '0;
          if (vec_count != 16'hFFFF) vec_count <= vec_count + 16'd1;
        end else begin
          elem <= elem + EW'(1);
        end
      end
      // Read port output doubles as the skid register: it only reloads when empty or consumed.
      if (rd_start_c) begin
        rd_ptr <= '0;
      end else if (rd_load_c) begin
        if (rd_ptr < wcnt) begin
          rd_data  <= mem[MAW'(rd_ptr)];
          rd_addr  <= AW'(rd_ptr);
          rd_valid <= 1'b1;
          rd_ptr   <= rd_ptr + WW'(1);
        end else begin
          rd_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_rls_result_logger.sv
// Directed bench: instance a uses N=16 with default depth, instance b uses DEPTH=4, N=2.
module tb_rls_result_logger;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic        a_reset = 1'b1, a_write = 1'b0, a_final = 1'b0, a_dump = 1'b0, a_rd_ready = 1'b0;
  logic [31:0] a_x = '0, a_rd_data;
  logic        a_rd_valid, a_ovf, a_done;
  logic [14:0] a_rd_addr, a_wr_addr;
  logic [15:0] a_vec;

  logic        b_reset = 1'b1, b_write = 1'b0, b_final = 1'b0, b_dump = 1'b0, b_rd_ready = 1'b0;
  logic [7:0]  b_x = '0, b_rd_data;
  logic        b_rd_valid, b_ovf, b_done;
  logic [2:0]  b_rd_addr, b_wr_addr;
  logic [15:0] b_vec;

  rls_result_logger #(.nBits(32), .N(16), .AW(15), .DEPTH(16384)) dut_a (
    .clk(clk), .reset(a_reset), .write(a_write), .x(a_x), .run_final(a_final),
    .dump(a_dump), .rd_ready(a_rd_ready), .rd_data(a_rd_data), .rd_valid(a_rd_valid),
    .rd_addr(a_rd_addr), .wr_addr(a_wr_addr), .vec_count(a_vec), .overflow(a_ovf), .done(a_done));

  rls_result_logger #(.nBits(8), .N(2), .AW(3), .DEPTH(4)) dut_b (
    .clk(clk), .reset(b_reset), .write(b_write), .x(b_x), .run_final(b_final),
    .dump(b_dump), .rd_ready(b_rd_ready), .rd_data(b_rd_data), .rd_valid(b_rd_valid),
    .rd_addr(b_rd_addr), .wr_addr(b_wr_addr), .vec_count(b_vec), .overflow(b_ovf), .done(b_done));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic reset_b;
    b_reset = 1'b1;
    tick();
    b_reset = 1'b0;
  endtask

  task automatic test_reset;
    a_x = 32'hDEAD_BEEF;
    a_write = 1'b1;
    tick();
    tick();
    a_write = 1'b0;
    checks++;
    if ({a_wr_addr, a_vec, a_ovf, a_done, a_rd_valid, a_rd_addr, a_rd_data} !== '0) begin
      failures++;
      $display("FAIL reset_a wr_addr=%0d vec=%0d ovf=%b done=%b rd_valid=%b rd_addr=%0d rd_data=%0h expected all zero",
               a_wr_addr, a_vec, a_ovf, a_done, a_rd_valid, a_rd_addr, a_rd_data);
    end
    checks++;
    if ({b_wr_addr, b_vec, b_ovf, b_done, b_rd_valid, b_rd_addr, b_rd_data} !== '0) begin
      failures++;
      $display("FAIL reset_b wr_addr=%0d vec=%0d ovf=%b done=%b rd_valid=%b expected all zero",
               b_wr_addr, b_vec, b_ovf, b_done, b_rd_valid);
    end
    a_reset = 1'b0;
    b_reset = 1'b0;
  endtask

  task automatic test_capture;
    for (int i = 1; i <= 32; i++) begin
      a_write = 1'b1;
      a_x = 32'(i);
      tick();
      if (i == 1) begin
        checks++;
        if (a_wr_addr !== 15'd1 || a_done !== 1'b0) begin
          failures++;
          $display("FAIL first_write wr_addr=%0d done=%b expected 1 0", a_wr_addr, a_done);
        end
      end
    end
    a_write = 1'b0;
    a_final = 1'b1;
    tick();
    a_final = 1'b0;
    checks++;
    if (a_wr_addr !== 15'd32 || a_vec !== 16'd2 || a_done !== 1'b1 || a_ovf !== 1'b0) begin
      failures++;
      $display("FAIL capture32 wr_addr=%0d vec=%0d done=%b ovf=%b expected 32 2 1 0",
               a_wr_addr, a_vec, a_done, a_ovf);
    end
  endtask

  task automatic test_dump;
    a_rd_ready = 1'b1;
    a_dump = 1'b1;
    tick();
    a_dump = 1'b0;
    checks++;
    if (a_rd_valid !== 1'b0) begin
      failures++;
      $display("FAIL dump_latency rd_valid=%b one cycle after dump expected 0", a_rd_valid);
    end
    tick();
    for (int k = 0; k < 32; k++) begin
      checks++;
      if (a_rd_valid !== 1'b1 || a_rd_data !== 32'(k + 1) || a_rd_addr !== 15'(k)) begin
        failures++;
        $display("FAIL dump_word%0d valid=%b data=%0d addr=%0d expected 1 %0d %0d",
                 k, a_rd_valid, a_rd_data, a_rd_addr, k + 1, k);
      end
      tick();
    end
    checks++;
    if (a_rd_valid !== 1'b0 || a_done !== 1'b1) begin
      failures++;
      $display("FAIL dump_end rd_valid=%b done=%b expected 0 1", a_rd_valid, a_done);
    end
  endtask

  task automatic test_stall;
    logic [3:0] pat;
    int idx;
    int guard;
    pat = 4'b1001;
    idx = 0;
    guard = 0;
    a_rd_ready = 1'b1;
    a_dump = 1'b1;
    tick();
    a_dump = 1'b0;
    while (!a_rd_valid && guard < 10) begin
      tick();
      guard++;
    end
    checks++;
    if (a_rd_valid !== 1'b1) begin
      failures++;
      $display("FAIL stall_start rd_valid=%b expected 1 within 10 cycles", a_rd_valid);
    end
    for (int c = 0; c < 200 && idx < 32; c++) begin
      checks++;
      if (a_rd_valid !== 1'b1 || a_rd_data !== 32'(idx + 1) || a_rd_addr !== 15'(idx)) begin
        failures++;
        $display("FAIL stall_cyc%0d valid=%b data=%0d addr=%0d expected 1 %0d %0d",
                 c, a_rd_valid, a_rd_data, a_rd_addr, idx + 1, idx);
      end
      a_rd_ready = pat[c % 4];
      if (a_rd_ready) idx++;
      tick();
    end
    a_rd_ready = 1'b1;
    checks++;
    if (idx != 32 || a_rd_valid !== 1'b0) begin
      failures++;
      $display("FAIL stall_end words=%0d rd_valid=%b expected 32 0", idx, a_rd_valid);
    end
  endtask

  task automatic test_overflow;
    reset_b();
    for (int i = 0; i < 6; i++) begin
      b_write = 1'b1;
      b_x = 8'hA + 8'(i);
      tick();
      if (i == 3) begin
        checks++;
        if (b_wr_addr !== 3'd4 || b_ovf !== 1'b0) begin
          failures++;
          $display("FAIL fill_exact wr_addr=%0d ovf=%b expected 4 0", b_wr_addr, b_ovf);
        end
      end
    end
    b_write = 1'b0;
    b_final = 1'b1;
    tick();
    b_final = 1'b0;
    checks++;
    if (b_wr_addr !== 3'd4 || b_ovf !== 1'b1 || b_done !== 1'b1 || b_vec !== 16'd2) begin
      failures++;
      $display("FAIL overflow wr_addr=%0d ovf=%b done=%b vec=%0d expected 4 1 1 2",
               b_wr_addr, b_ovf, b_done, b_vec);
    end
    b_write = 1'b1;
    b_x = 8'h55;
    tick();
    b_write = 1'b0;
    checks++;
    if (b_wr_addr !== 3'd4 || b_done !== 1'b1 || b_ovf !== 1'b1) begin
      failures++;
      $display("FAIL hold_write wr_addr=%0d done=%b ovf=%b expected 4 1 1", b_wr_addr, b_done, b_ovf);
    end
    b_rd_ready = 1'b1;
    b_dump = 1'b1;
    tick();
    b_dump = 1'b0;
    tick();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (b_rd_valid !== 1'b1 || b_rd_data !== 8'hA + 8'(k) || b_rd_addr !== 3'(k)) begin
        failures++;
        $display("FAIL ovf_word%0d valid=%b data=%0h addr=%0d expected 1 %0h %0d",
                 k, b_rd_valid, b_rd_data, b_rd_addr, 8'hA + 8'(k), k);
      end
      tick();
    end
    checks++;
    if (b_rd_valid !== 1'b0) begin
      failures++;
      $display("FAIL ovf_dump_end rd_valid=%b expected 0", b_rd_valid);
    end
  endtask

  task automatic test_empty_dump;
    bit seen;
    reset_b();
    b_final = 1'b1;
    tick();
    b_final = 1'b0;
    checks++;
    if (b_done !== 1'b1 || b_wr_addr !== 3'd0) begin
      failures++;
      $display("FAIL empty_hold done=%b wr_addr=%0d expected 1 0", b_done, b_wr_addr);
    end
    b_dump = 1'b1;
    tick();
    b_dump = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (b_rd_valid !== 1'b0) seen = 1'b1;
      tick();
    end
    checks++;
    if (seen || b_done !== 1'b1) begin
      failures++;
      $display("FAIL empty_dump rd_valid_seen=%b done=%b expected 0 1", seen, b_done);
    end
  endtask

  task automatic test_same_cycle_final;
    reset_b();
    for (int i = 1; i <= 3; i++) begin
      b_write = 1'b1;
      b_x = 8'(i);
      b_final = (i == 3);
      tick();
    end
    b_write = 1'b0;
    b_final = 1'b0;
    checks++;
    if (b_wr_addr !== 3'd3 || b_done !== 1'b1 || b_ovf !== 1'b0 || b_vec !== 16'd1) begin
      failures++;
      $display("FAIL write_final wr_addr=%0d done=%b ovf=%b vec=%0d expected 3 1 0 1",
               b_wr_addr, b_done, b_ovf, b_vec);
    end
    b_rd_ready = 1'b1;
    b_dump = 1'b1;
    tick();
    b_dump = 1'b0;
    tick();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (b_rd_valid !== 1'b1 || b_rd_data !== 8'(k + 1) || b_rd_addr !== 3'(k)) begin
        failures++;
        $display("FAIL wf_word%0d valid=%b data=%0d addr=%0d expected 1 %0d %0d",
                 k, b_rd_valid, b_rd_data, b_rd_addr, k + 1, k);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_dump;
    bit seen;
    a_rd_ready = 1'b1;
    a_dump = 1'b1;
    tick();
    a_dump = 1'b0;
    tick();
    for (int k = 0; k < 5; k++) tick();
    checks++;
    if (a_rd_valid !== 1'b1 || a_rd_addr !== 15'd5 || a_rd_data !== 32'd6) begin
      failures++;
      $display("FAIL pre_reset valid=%b addr=%0d data=%0d expected 1 5 6", a_rd_valid, a_rd_addr, a_rd_data);
    end
    a_reset = 1'b1;
    tick();
    a_reset = 1'b0;
    checks++;
    if (a_rd_valid !== 1'b0 || a_done !== 1'b0 || a_wr_addr !== 15'd0 || a_vec !== 16'd0) begin
      failures++;
      $display("FAIL reset_dump valid=%b done=%b wr_addr=%0d vec=%0d expected 0 0 0 0",
               a_rd_valid, a_done, a_wr_addr, a_vec);
    end
    a_dump = 1'b1;
    tick();
    a_dump = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (a_rd_valid !== 1'b0 || a_done !== 1'b0) seen = 1'b1;
      tick();
    end
    checks++;
    if (seen) begin
      failures++;
      $display("FAIL dump_after_reset output_seen=%b expected 0", seen);
    end
  endtask

  initial begin
    test_reset();
    test_capture();
    test_dump();
    test_stall();
    test_overflow();
    test_empty_dump();
    test_same_cycle_final();
    test_reset_mid_dump();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rls_result_logger.md
RLS_RESULT_LOGGER -- requirements
Module: rls_result_logger

Interface
REQ-001 SHALL have parameter nBits, default 32, width of each solution word x.
REQ-002 SHALL have parameter N, default 16, words per solution vector.
REQ-003 SHALL have parameter AW, default 15, address width.
REQ-004 SHALL have parameter DEPTH, default 16384, capture words, 1 <= DEPTH <= 2^AW.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 reset  in  1  synchronous, active-high.
REQ-007 write  in  1  x valid strobe from RLS stage, one word per high cycle.
REQ-008 x  in  nBits  solution word from RLS stage.
REQ-009 final  in  1  RLS run complete; sampled level, first high cycle counts.
REQ-010 dump  in  1  readback start request.
REQ-011 rd_ready  in  1  readback consumer ready.
REQ-012 rd_data  out  nBits  readback word.
REQ-013 rd_valid  out  1  rd_data valid.
REQ-014 rd_addr  out  AW  address of word on rd_data.
REQ-015 wr_addr  out  AW  words captured so far.
REQ-016 vec_count  out  16  complete N-word vectors captured.
REQ-017 overflow  out  1  sticky: at least one write dropped.
REQ-018 done  out  1  capture closed; data available for dump.

Function
REQ-019 SHALL hold a DEPTH x nBits internal memory: one synchronous write port, one synchronous read port, one-cycle read latency.
REQ-020 SHALL implement states IDLE, CAPTURE, HOLD, DUMP.
REQ-021 IDLE: write=1 -> store x at address 0, wr_addr=1, go CAPTURE; final=1 with no write -> HOLD with wr_addr=0.
REQ-022 CAPTURE: each write=1 with wr_addr<DEPTH -> store x at wr_addr, wr_addr+1 next cycle.
REQ-023 CAPTURE: write=1 with wr_addr==DEPTH -> word dropped, overflow=1; wr_addr never wraps.
REQ-024 CAPTURE: final=1 -> HOLD next cycle; a write in the same cycle is stored first (or dropped per REQ-023).
REQ-025 SHALL keep an element counter 0..N-1 advancing on each stored word; on wrap N-1->0, vec_count increments, saturating at 65535.
REQ-026 write=1 in HOLD or DUMP -> word dropped, overflow=1, memory and wr_addr unchanged.
REQ-027 done SHALL be 1 in HOLD and DUMP, 0 in IDLE and CAPTURE.
REQ-028 HOLD: dump=1 with wr_addr>0 -> DUMP, read address 0 issued; dump=1 with wr_addr==0 -> stays HOLD, rd_valid stays 0.
REQ-029 DUMP: rd_valid first asserted 2 cycles after the accepting dump cycle, with rd_addr=0 and rd_data=mem[0].
REQ-030 Transfer occurs on a cycle with rd_valid=1 and rd_ready=1; next word presented on the following cycle when available (one word/cycle sustained).
REQ-031 rd_valid=1, rd_ready=0 -> rd_data and rd_addr SHALL hold stable; rd_valid SHALL stay 1.
REQ-032 Transfer at rd_addr==wr_addr-1 -> rd_valid=0 next cycle, return to HOLD; a further dump repeats the full readback.
REQ-033 dump in IDLE, CAPTURE, or DUMP SHALL be ignored.
REQ-034 Memory contents SHALL NOT be cleared by reset; only wr_addr bounds readable data.

Reset
REQ-035 reset=1 SHALL force, next edge: state IDLE, wr_addr=0, vec_count=0, element counter=0, overflow=0, done=0, rd_valid=0, rd_addr=0, rd_data=0.
REQ-036 reset SHALL override all other inputs in the same cycle, including mid-CAPTURE and mid-DUMP; a pending readback is abandoned with no further rd_valid.

Verification
REQ-037 N=16: 32 write pulses x=1..32, then final -> wr_addr=32, vec_count=2, done=1, overflow=0.
REQ-038 After REQ-037, dump pulse, rd_ready=1 constant -> rd_valid at +2 cycles, 32 consecutive words 1..32 with rd_addr 0..31, then HOLD.
REQ-039 Readback with rd_ready toggling 1,0,0,1 -> no word lost or duplicated; rd_data stable during stalls.
REQ-040 DEPTH=4: 6 writes x=A..F then final -> wr_addr=4, mem holds A..D, overflow=1; write in HOLD keeps wr_addr=4.
REQ-041 write and final in the same cycle as the 3rd word -> word stored, wr_addr=3, HOLD next cycle.
REQ-042 reset asserted mid-DUMP after 5 transfers -> rd_valid=0, done=0, wr_addr=0 next cycle; a subsequent dump produces no output.
